// File: rtl/ram_responder.sv
// Single-word BRAM responder behind the memory arbiter's RAM port.
// One read or write at a time, programmable access latency, ramBUSY handshake.
module ram_responder #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] OOB_DATA    = 32'hBAD1BAD1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [ADDR_W-1:0] ramaddr,
   input  logic [31:0]       ramstore,
   input  logic              ramREN,
   input  logic              ramWEN,
   output logic [31:0]       ramload,
   output logic              ramBUSY,
   output logic              addr_err,
   output logic [15:0]       txn_count
);

   localparam int unsigned IdxW     = ADDR_W - 2;
   localparam int unsigned MemW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned ExtW     = IdxW + 32;
   localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);
   localparam logic [ExtW-1:0] DepthExt = ExtW'(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [31:0]       data_q, data_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              oob_q, oob_d;
   logic [31:0]       load_q, load_d;
   logic [15:0]       txn_q, txn_d;

   logic [31:0]       mem [DEPTH_WORDS];
   logic              req;
   logic [IdxW-1:0]   live_idx;
   logic              in_range;
   logic [MemW-1:0]   mem_idx;
   logic              mem_we;
   logic              unused_lsb;

   assign req        = ramREN | ramWEN;
   assign live_idx   = ramaddr[ADDR_W-1:2];
   assign unused_lsb = ^ramaddr[1:0];
   // Compare in a widened space so any index width against any depth is exact.
   assign in_range   = ({32'd0, idx_q} < DepthExt);
   assign mem_idx    = idx_q[MemW-1:0];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      oob_d   = oob_q;
      load_d  = load_q;
      txn_d   = txn_q;
      mem_we  = 1'b0;
      ramBUSY = 1'b0;

      case (state_q)
         StIdle: begin
            if (req) begin
               ramBUSY = 1'b1;
               idx_d   = live_idx;
               wr_d    = ramWEN;
               data_d  = ramstore;
               cnt_d   = CntInit;
               state_d = StAccess;
            end
         end

         StAccess: begin
            ramBUSY = 1'b1;
            if (!req) begin
               state_d = StIdle;
            end else if ((live_idx != idx_q) || (ramWEN != wr_q)) begin
               idx_d  = live_idx;
               wr_d   = ramWEN;
               data_d = ramstore;
               cnt_d  = CntInit;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               oob_d  = ~in_range;
               mem_we = wr_q & in_range;
               if (!wr_q) begin
                  load_d = in_range ? mem[mem_idx] : OOB_DATA;
               end
               state_d = StDone;
            end
         end

         StDone: begin
            txn_d   = txn_q + 16'd1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         oob_q   <= 1'b0;
         load_q  <= '0;
         txn_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         oob_q   <= oob_d;
         load_q  <= load_d;
         txn_q   <= txn_d;
      end
   end

   // Array is deliberately not reset; a reset mid-ACCESS simply never reaches here.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_idx] <= data_q;
      end
   end

   assign ramload   = load_q;
   assign addr_err  = (state_q == StDone) & oob_q;
   assign txn_count = txn_q;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: two instances (LATENCY 2 and 1) checked
// against a transaction-level memory model.
module tb_ram_responder;

   localparam int unsigned Depth = 1024;
   localparam logic [31:0] Oob   = 32'hBAD1BAD1;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] ramaddr, ramstore;
   logic        ren, wen;
   int          sel;

   logic        ren0, wen0, ren1, wen1;
   logic [31:0] load0, load1, load_s;
   logic        busy0, busy1, busy_s, err0, err1, err_s;
   logic [15:0] txn0, txn1, txn_s;

   assign ren0   = ren & (sel == 0);
   assign wen0   = wen & (sel == 0);
   assign ren1   = ren & (sel == 1);
   assign wen1   = wen & (sel == 1);
   assign load_s = (sel == 1) ? load1 : load0;
   assign busy_s = (sel == 1) ? busy1 : busy0;
   assign err_s  = (sel == 1) ? err1 : err0;
   assign txn_s  = (sel == 1) ? txn1 : txn0;

   always #5 CLK = ~CLK;

   ram_responder #(.ADDR_W(32), .DEPTH_WORDS(Depth), .LATENCY(2), .OOB_DATA(Oob)) u_dut0 (
      .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ren0),
      .ramWEN(wen0), .ramload(load0), .ramBUSY(busy0), .addr_err(err0), .txn_count(txn0)
   );

   ram_responder #(.ADDR_W(32), .DEPTH_WORDS(Depth), .LATENCY(1), .OOB_DATA(Oob)) u_dut1 (
      .CLK(CLK), .nRST(nRST), .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ren1),
      .ramWEN(wen1), .ramload(load1), .ramBUSY(busy1), .addr_err(err1), .txn_count(txn1)
   );

   int          lat [2] = '{2, 1};
   logic [31:0] mdl [2][Depth];
   logic [31:0] exp_load [2];
   int          exp_txn [2];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Checks a completion seen n cycles after the final request pattern began.
   task automatic finish_txn(input int s, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input int n, input int exp_n);
      int unsigned widx;
      bit          oob;
      widx = a >> 2;
      oob  = (widx >= Depth);
      check("latency", n, exp_n);
      if (!busy_s) begin
         if (!w) exp_load[s] = oob ? Oob : mdl[s][widx];
         else if (!oob) mdl[s][widx] = d;
         check("ramload", load_s, exp_load[s]);
         check("addr_err", err_s, oob);
         check("txn_in_done", txn_s, exp_txn[s]);
         exp_txn[s] = (exp_txn[s] + 1) & 16'hFFFF;
      end
      ren = 1'b0;
      wen = 1'b0;
      @(negedge CLK);
      check("txn_after", txn_s, exp_txn[s]);
      check("err_clear", err_s, 1'b0);
      check("idle_busy", busy_s, 1'b0);
   endtask

   task automatic do_txn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge CLK);
      sel      = s;
      ramaddr  = a;
      ramstore = d;
      wen      = w;
      ren      = !w || ($urandom_range(0, 1) == 1);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         if (w) ramstore = $urandom;
      end while (busy_s && n < 40);
      finish_txn(s, w, a, d, n, lat[s] + 1);
   endtask

   // Start a read at a0, then change address/op in the first ACCESS cycle.
   task automatic switch_txn(input int s, input logic [31:0] a0, input bit w1,
                             input logic [31:0] a1, input logic [31:0] d1);
      int n;
      @(negedge CLK);
      sel = s; ramaddr = a0; ren = 1'b1; wen = 1'b0;
      @(negedge CLK);
      check("switch_busy", busy_s, 1'b1);
      ramaddr = a1; wen = w1; ramstore = d1;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (busy_s && n < 40);
      finish_txn(s, w1, a1, d1, n, lat[s] + 1);
   endtask

   initial begin
      int          n;
      logic [31:0] old_load;
      int          old_txn;

      nRST = 1'b0; ren = 1'b0; wen = 1'b0; sel = 0; ramaddr = '0; ramstore = '0;
      exp_load = '{32'd0, 32'd0};
      exp_txn  = '{0, 0};
      #12;
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         check("rst_load", load_s, 32'd0);
         check("rst_busy", busy_s, 1'b0);
         check("rst_err", err_s, 1'b0);
         check("rst_txn", txn_s, 16'd0);
      end
      @(negedge CLK);
      nRST = 1'b1;

      // Write then read back.
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
      do_txn(0, 1'b0, 32'h10, 32'h0);
      check("wr_rd_data", load0, 32'hDEADBEEF);
      check("wr_rd_txn", txn0, 16'd2);

      // Preload the random address pool on both instances.
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 32; i++) do_txn(s, 1'b1, 32'(i * 4), $urandom);

      // Read held continuously: back-to-back completions.
      do_txn(0, 1'b1, 32'h20, 32'h1234);
      @(negedge CLK);
      sel = 0; ramaddr = 32'h20; ren = 1'b1; wen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            @(negedge CLK);
            n++;
         end while (busy_s && n < 40);
         check("hold_period", n, (k == 0) ? 3 : 4);
         check("hold_load", load_s, 32'h1234);
         check("hold_txn", txn_s, exp_txn[0]);
         exp_txn[0]++;
      end
      ren = 1'b0;
      exp_load[0] = 32'h1234;
      @(negedge CLK);
      check("hold_txn_after", txn0, exp_txn[0]);

      // Aborted read, then a normal read.
      do_txn(0, 1'b1, 32'h30, 32'h3030_3030);
      old_load = exp_load[0];
      old_txn  = exp_txn[0];
      @(negedge CLK);
      sel = 0; ramaddr = 32'h30; ren = 1'b1;
      @(negedge CLK);
      check("abort_busy", busy0, 1'b1);
      ren = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         check("abort_err", err0, 1'b0);
      end
      check("abort_load", load0, old_load);
      check("abort_txn", txn0, old_txn);
      do_txn(0, 1'b0, 32'h34, 32'h0);

      // Restarts: address change, then op change read->write.
      switch_txn(0, 32'h40, 1'b0, 32'h44, 32'h0);
      switch_txn(0, 32'h48, 1'b1, 32'h48, 32'h4848_0001);
      do_txn(0, 1'b0, 32'h48, 32'h0);
      switch_txn(1, 32'h40, 1'b0, 32'h44, 32'h0);

      // Out-of-range read and write; index aliases onto word 0.
      do_txn(0, 1'b1, 32'h0, 32'h0000_0C0C);
      do_txn(0, 1'b0, 32'h1000, 32'h0);
      do_txn(0, 1'b1, 32'h1000, 32'hFFFF_0000);
      do_txn(0, 1'b0, 32'h0, 32'h0);
      check("oob_no_alias", load0, 32'h0000_0C0C);

      // Reset in the middle of a write.
      do_txn(0, 1'b1, 32'h50, 32'h5555);
      @(negedge CLK);
      sel = 0; ramaddr = 32'h50; ramstore = 32'hAAAA; wen = 1'b1;
      @(negedge CLK);
      nRST = 1'b0; wen = 1'b0; ren = 1'b0;
      #1;
      check("rst_mid_busy", busy0, 1'b0);
      check("rst_mid_txn", txn0, 16'd0);
      check("rst_mid_load", load0, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      exp_txn  = '{0, 0};
      exp_load = '{32'd0, 32'd0};
      do_txn(0, 1'b0, 32'h50, 32'h0);
      check("rst_discard", load0, 32'h5555);
      do_txn(1, 1'b0, 32'h50, 32'h0);

      // Random traffic on both instances.
      for (int i = 0; i < 80; i++) begin
         int unsigned idx;
         idx = ($urandom_range(0, 7) == 0) ? 1024 + $urandom_range(0, 3) : $urandom_range(0, 31);
         do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 32'(idx * 4), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
